// File: rtl/ps2_rx_frame_if.sv
// Scancode output bus from the PS/2 frame receiver to the scancode-to-digit decoder.
interface ps2_rx_frame_if;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       frame_err;

  modport master (output code, code_valid, is_break, frame_err);
  modport slave  (input  code, code_valid, is_break, frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 serial receiver: synchronizes ps2_clk/ps2_data, deserializes 11-bit frames, checks framing.
// Optional break-code tagging is enabled with `define PS2_RX_BREAK_TAG_EN.
module ps2_rx_frame #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_rx_frame_if.master        code_if
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] BREAK_CODE = 8'hF0;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           r_state, w_state_n;
  logic             r_clk_s1, r_clk_s2, r_clk_hist, r_dat_s1, r_dat_s2;
  logic [7:0]       r_shift, w_shift_n;
  logic [2:0]       r_bitcnt, w_bitcnt_n;
  logic             r_par, w_par_n;
  logic [TMR_W-1:0] r_tmr, w_tmr_n;
  logic [7:0]       r_code, w_code_n;
  logic             r_code_valid, w_code_valid_n;
  logic             r_frame_err, w_frame_err_n;
  logic             w_fall, w_bit, w_ok;
`ifdef PS2_RX_BREAK_TAG_EN
  logic             r_is_break, w_is_break_n;
  logic             r_brk, w_brk_n;
`endif

  // Two-flop synchronizers plus ps2_clk history; idle bus reads high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_hist <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_hist <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fall = r_clk_hist & ~r_clk_s2;
  assign w_bit  = r_dat_s2;
  assign w_ok   = (^r_shift ^ r_par) & w_bit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_par        <= 1'b0;
      r_tmr        <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef PS2_RX_BREAK_TAG_EN
      r_is_break   <= 1'b0;
      r_brk        <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_n;
      r_shift      <= w_shift_n;
      r_bitcnt     <= w_bitcnt_n;
      r_par        <= w_par_n;
      r_tmr        <= w_tmr_n;
      r_code       <= w_code_n;
      r_code_valid <= w_code_valid_n;
      r_frame_err  <= w_frame_err_n;
`ifdef PS2_RX_BREAK_TAG_EN
      r_is_break   <= w_is_break_n;
      r_brk        <= w_brk_n;
`endif
    end
  end

  // Frame FSM, inter-bit timer and output pulse generation.
  always_comb begin
    w_state_n      = r_state;
    w_shift_n      = r_shift;
    w_bitcnt_n     = r_bitcnt;
    w_par_n        = r_par;
    w_code_n       = r_code;
    w_code_valid_n = 1'b0;
    w_frame_err_n  = 1'b0;
`ifdef PS2_RX_BREAK_TAG_EN
    w_is_break_n   = r_is_break;
    w_brk_n        = r_brk;
`endif
    w_tmr_n        = (r_state == IDLE || w_fall) ? '0 : r_tmr + TMR_W'(1);

    unique case (r_state)
      IDLE: begin
        if (w_fall && !w_bit) begin
          w_state_n  = DATA;
          w_bitcnt_n = '0;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift_n  = {w_bit, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_n = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) begin
          w_par_n   = w_bit;
          w_state_n = STOP;
        end
      end
      STOP: begin
        if (w_fall) begin
          w_state_n = IDLE;
          if (w_ok) begin
`ifdef PS2_RX_BREAK_TAG_EN
            if (r_shift == BREAK_CODE) begin
              w_brk_n = 1'b1;
            end else begin
              w_code_n       = r_shift;
              w_code_valid_n = 1'b1;
              w_is_break_n   = r_brk;
              w_brk_n        = 1'b0;
            end
`else
            w_code_n       = r_shift;
            w_code_valid_n = 1'b1;
`endif
          end else begin
            w_frame_err_n = 1'b1;
`ifdef PS2_RX_BREAK_TAG_EN
            w_brk_n       = 1'b0;
`endif
          end
        end
      end
      default: w_state_n = IDLE;
    endcase

    // A fall in the terminal cycle wins; otherwise abort the partial frame.
    if (r_state != IDLE && !w_fall && r_tmr == TMR_LAST) begin
      w_state_n     = IDLE;
      w_shift_n     = '0;
      w_frame_err_n = 1'b1;
`ifdef PS2_RX_BREAK_TAG_EN
      w_brk_n       = 1'b0;
`endif
    end
  end

  assign code_if.code       = r_code;
  assign code_if.code_valid = r_code_valid;
  assign code_if.frame_err  = r_frame_err;
`ifdef PS2_RX_BREAK_TAG_EN
  assign code_if.is_break   = r_is_break;
`else
  assign code_if.is_break   = 1'b0;
`endif

endmodule
